// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch/decode slice: opcode constants,
// fetch FSM state encoding, PC width and small field-extraction helpers.
package mips_pkg;

    // Architectural PC / instruction width
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;

    // Primary opcode field values (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // Fetch stage state encoding; the spare code is treated as a halt-like trap
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    // Opcode field of an instruction word
    function automatic logic [OP_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

    // Sign-extended, word-scaled branch displacement
    function automatic logic [PC_W-1:0] branch_offset(input logic [INSTR_W-1:0] instr);
        return {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    // Force a byte address onto a word boundary
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken-branch target or pc+4.
// Kept free of state so a pipelined fetch can reuse it directly.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    output logic [PC_W-1:0]    next_pc
);

    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_jump_target;
    logic [PC_W-1:0] w_branch_target;
    logic [OP_W-1:0] w_unused_opcode;

    // The opcode does not steer the target; the decoder's branch/jump do
    assign w_unused_opcode = instr[31:26];

    // Sequential successor, wraps modulo 2^32
    assign w_pc4 = pc + 32'd4;

    // Pseudo-direct jump keeps the upper nibble of pc+4
    assign w_jump_target = {w_pc4[31:28], instr[25:0], 2'b00};

    // PC-relative branch target, wraps modulo 2^32
    assign w_branch_target = w_pc4 + branch_offset(instr);

    // Select the successor; jump wins over a taken branch
    always_comb begin
        next_pc = w_pc4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (branch && zero) begin
            next_pc = w_branch_target;
        end else begin
            next_pc = w_pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over a req/ready handshake,
// holds the fetched word for the decoder, and stops on the halt opcode or on a
// memory read that does not complete within TIMEOUT_CYCLES wait cycles.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE    = 6'b111111,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault
);

    // Low address bits of the reset vector are never honoured
    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    // Wait-cycle limit in counter width (legal range 1..255)
    localparam logic [7:0]      TIMEOUT_LIMIT    = 8'(TIMEOUT_CYCLES);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_next;
    logic [7:0]         r_wait_cnt;
    logic [7:0]         w_wait_next;
    logic               r_fault;
    logic               w_fault_next;
    logic [PC_W-1:0]    w_next_pc;

    // Successor PC for the instruction currently held in r_instr
    next_pc_calc u_next_pc_calc (
        .pc      (r_pc),
        .instr   (r_instr),
        .branch  (branch),
        .jump    (jump),
        .zero    (alu_zero),
        .next_pc (w_next_pc)
    );

    // State register and datapath registers; reset drops any outstanding request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC_ALIGNED;
            r_instr    <= 32'h0000_0000;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_wait_cnt <= w_wait_next;
            r_fault    <= w_fault_next;
        end
    end

    // Next-state and datapath update; everything holds unless the state acts on it
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_wait_next  = r_wait_cnt;
        w_fault_next = r_fault;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_next = imem_rdata;
                    if (get_opcode(imem_rdata) == HALT_OPCODE) begin
                        w_state_next = S_HALT;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end else begin
                    if (r_wait_cnt >= (TIMEOUT_LIMIT - 8'd1)) begin
                        w_wait_next  = TIMEOUT_LIMIT;
                        w_fault_next = 1'b1;
                        w_state_next = S_HALT;
                    end else begin
                        w_wait_next  = r_wait_cnt + 8'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_ack) begin
                    w_pc_next    = word_align(w_next_pc);
                    w_wait_next  = 8'd0;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                // Unreachable encoding: park safely and flag it
                w_fault_next = 1'b1;
                w_state_next = S_HALT;
            end
        endcase
    end

    // Handshake/status outputs decoded from the state register
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign pc_out    = r_pc;
    assign instr_out = r_instr;
    assign opcode    = get_opcode(r_instr);
    assign fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized instruction stream checked against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch;
    logic        jump;
    logic        alu_zero;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_pc;

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .HALT_OPCODE    (6'b111111),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .branch      (branch),
        .jump        (jump),
        .alu_zero    (alu_zero),
        .pc_out      (pc_out),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: unknown addresses get a random non-halt instruction
    task automatic get_word(input logic [31:0] a, output logic [31:0] w);
        logic [5:0] op;
        if (!mem.exists(a)) begin
            op = 6'($urandom_range(0, 62));
            mem[a] = {op, 26'($urandom)};
        end
        w = mem[a];
    endtask

    // Architectural successor PC
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit br, input bit jp, input bit zr);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        if (jp) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br && zr) begin
            off = int'($signed(w[15:0])) * 4;
            return pc4 + 32'(off);
        end
        return pc4;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        instr_ack  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_zero   = 1'b0;
        tick();
        tick();
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted},      32'd0);
        chk("rst_fault",  {31'd0, fault},       32'd0);
        chk("rst_pc",     pc_out,               32'h0);
        chk("rst_instr",  instr_out,            32'h0);
        rst_n = 1'b1;
        m_pc  = 32'h0;
    endtask

    // One fetch/issue transaction: lat wait cycles, stall cycles of held valid, then ack
    task automatic run_instr(input int lat, input int stall, input bit br, input bit jp, input bit zr);
        logic [31:0] w;
        get_word(m_pc, w);
        chk("fetch_req",  {31'd0, imem_req},    32'd1);
        chk("fetch_addr", imem_addr,            m_pc);
        chk("fetch_vld",  {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < lat; i++) begin
            imem_ready = 1'b0;
            instr_ack  = 1'($urandom);
            tick();
            chk("wait_req",   {31'd0, imem_req}, 32'd1);
            chk("wait_addr",  imem_addr,         m_pc);
            chk("wait_fault", {31'd0, fault},    32'd0);
        end
        instr_ack  = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = w;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        if (w[31:26] == 6'h3F) begin
            for (int i = 0; i < 3; i++) begin
                chk("halt_halted", {31'd0, halted},      32'd1);
                chk("halt_req",    {31'd0, imem_req},    32'd0);
                chk("halt_vld",    {31'd0, instr_valid}, 32'd0);
                chk("halt_opcode", {26'd0, opcode},      32'h3F);
                chk("halt_instr",  instr_out,            w);
                imem_ready = 1'($urandom);
                instr_ack  = 1'b1;
                tick();
            end
            instr_ack  = 1'b0;
            imem_ready = 1'b0;
            return;
        end
        chk("issue_vld",    {31'd0, instr_valid}, 32'd1);
        chk("issue_req",    {31'd0, imem_req},    32'd0);
        chk("issue_instr",  instr_out,            w);
        chk("issue_opcode", {26'd0, opcode},      {26'd0, w[31:26]});
        chk("issue_pc",     pc_out,               m_pc);
        for (int i = 0; i < stall; i++) begin
            instr_ack  = 1'b0;
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            branch     = 1'($urandom);
            jump       = 1'($urandom);
            alu_zero   = 1'($urandom);
            tick();
            chk("stall_vld",   {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr_out,            w);
            chk("stall_pc",    pc_out,               m_pc);
        end
        imem_ready = 1'b0;
        instr_ack  = 1'b1;
        branch     = br;
        jump       = jp;
        alu_zero   = zr;
        tick();
        instr_ack  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_zero   = 1'b0;
        m_pc = ref_next(m_pc, w, br, jp, zr);
        chk("next_addr", imem_addr, m_pc);
        chk("next_lsb",  {30'd0, pc_out[1:0]}, 32'd0);
    endtask

    initial begin
        imem_rdata = 32'h0;
        mem[32'h0000_0000] = 32'h2008_0005;
        mem[32'h0000_0004] = 32'h0800_0004;
        mem[32'h0000_0010] = 32'h1000_FFFC;
        mem[32'h0000_0014] = 32'h0BFF_FFFF;
        mem[32'h1000_0008] = 32'h0800_0040;
        mem[32'h1000_0100] = 32'hFC00_0000;

        do_reset();
        run_instr(0, 3, 1'b0, 1'b0, 1'b0);  // addi at 0, stalled ack -> 0x4
        run_instr(1, 0, 1'b0, 1'b1, 1'b0);  // jump -> 0x10
        run_instr(0, 1, 1'b1, 1'b0, 1'b1);  // beq taken -> 0x04
        run_instr(2, 0, 1'b0, 1'b1, 1'b0);  // jump -> 0x10
        run_instr(0, 0, 1'b1, 1'b0, 1'b0);  // beq not taken -> 0x14
        run_instr(0, 0, 1'b0, 1'b1, 1'b0);  // jump -> 0x0FFF_FFFC
        run_instr(3, 0, 1'b0, 1'b0, 1'b0);  // -> 0x1000_0000
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);  // -> 0x1000_0008
        run_instr(0, 0, 1'b1, 1'b1, 1'b1);  // jump beats branch -> 0x1000_0100
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);  // halt word

        // Timeout with ready held low, then recovery through reset
        do_reset();
        imem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                chk("to_pre_fault", {31'd0, fault},    32'd0);
                chk("to_pre_req",   {31'd0, imem_req}, 32'd1);
            end else begin
                chk("to_fault",  {31'd0, fault},    32'd1);
                chk("to_halted", {31'd0, halted},   32'd1);
                chk("to_req",    {31'd0, imem_req}, 32'd0);
            end
        end
        tick();
        chk("to_sticky", {31'd0, fault}, 32'd1);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hFC00_0000;
        tick();
        imem_ready = 1'b0;
        chk("rec_fault",  {31'd0, fault},  32'd0);
        chk("rec_halted", {31'd0, halted}, 32'd0);
        chk("rec_instr",  instr_out,       32'h0);
        tick();
        rst_n = 1'b1;
        m_pc  = 32'h0;
        chk("rec_req",  {31'd0, imem_req}, 32'd1);
        chk("rec_addr", imem_addr,         32'h0);

        // Backward branch below zero wraps, then pc+4 wraps back to zero
        mem[32'h0000_0000] = 32'h1000_FFFE;
        run_instr(0, 0, 1'b1, 1'b0, 1'b1);  // -> 0xFFFF_FFFC
        chk("wrap_hi", imem_addr, 32'hFFFF_FFFC);
        run_instr(1, 0, 1'b0, 1'b0, 1'b0);  // -> 0x0000_0000
        chk("wrap_zero", imem_addr, 32'h0);

        // Randomized stream
        for (int n = 0; n < 150; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        mem[m_pc] = 32'hFC00_0000;
        run_instr(0, 0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
